permute_stream: RTL

Streaming pi-step permuter for the matrix-encoder permute stage. Accepts one N×N slice line per valid/ready handshake and applies the Keccak-style pi permutation to it 0–7 times, forward or inverse, chosen per line. Holds the result until the downstream stage accepts it. Counts output lines, flags the last line of each SLICES-line frame and pulses a frame-done strobe. It is the parametrised successor of the fixed 25-bit, 64-line permute datapath, and adds flow control, multi-pass operation and inverse mode.

---
 rtl/permute_stream_if.sv | 25 ++
 rtl/permute_stream.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/permute_stream_if.sv
// Line-stream bundle for permute_stream: upstream line handshake plus downstream result handshake.
// master drives lines in and accepts results; slave is the permuter itself.
interface permute_stream_if #(
  parameter int unsigned W = 25
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_line;
  logic [2:0]   passes;
  logic         inverse;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_line;
  logic         out_last;

  modport master (
    output in_valid, in_line, passes, inverse, out_ready,
    input  in_ready, out_valid, out_line, out_last
  );

  modport slave (
    input  in_valid, in_line, passes, inverse, out_ready,
    output in_ready, out_valid, out_line, out_last
  );
endinterface

// File: rtl/permute_stream.sv
// Streaming Keccak-style pi permuter: 0-7 pi steps per line, result held until accepted, frame counting.
// PERMUTE_INVERSE_EN: when defined, the per-line inverse flag selects the inverse pi map.
module permute_stream #(
  parameter int unsigned N      = 5,
  parameter int unsigned SLICES = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic             clk,
  input  logic             rst,
  permute_stream_if.slave  bus,
  output logic [CNT_W-1:0] line_cnt,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned W     = N * N;
  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, PERM, HOLD} state_t;

  state_t         state;
  logic [W-1:0]   data_q;
  logic [2:0]     left_q;
  logic           out_valid_q;
  logic           in_hs_c;
  logic           out_hs_c;
  logic           last_c;

  // out(x,y) = in((x+3y) mod N, x)
  function automatic logic [W-1:0] pi_fwd(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned y = 0; y < N; y++) begin
      for (int unsigned x = 0; x < N; x++) begin
        r[IDX_W'(x + N * y)] = d[IDX_W'(((x + 3 * y) % N) + N * x)];
      end
    end
    return r;
  endfunction

`ifdef PERMUTE_INVERSE_EN
  function automatic int unsigned calc_inv3(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned k = 1; k < n; k++) begin
      if (((3 * k) % n == 1) && (r == 0)) r = k;
    end
    return r;
  endfunction

  localparam int unsigned INV3 = calc_inv3(N);

  // out(x,y) = in(y, ((x-y)*inv3) mod N); x-y+N stays non-negative
  function automatic logic [W-1:0] pi_inv(input logic [W-1:0] d);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned y = 0; y < N; y++) begin
      for (int unsigned x = 0; x < N; x++) begin
        r[IDX_W'(x + N * y)] = d[IDX_W'(y + N * (((x + N - y) * INV3) % N))];
      end
    end
    return r;
  endfunction

  logic inv_q;
`else
  logic unused_inverse;
  assign unused_inverse = bus.inverse;
`endif

  assign bus.in_ready  = (state == IDLE) || ((state == HOLD) && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_line  = data_q;
  assign last_c        = (line_cnt == CNT_W'(SLICES - 1));
  assign bus.out_last  = out_valid_q && last_c;
  assign in_hs_c       = bus.in_valid && bus.in_ready;
  assign out_hs_c      = out_valid_q && bus.out_ready;

  // FSM, datapath and frame counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      data_q      <= '0;
      left_q      <= '0;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
      line_cnt    <= '0;
      frame_done  <= 1'b0;
`ifdef PERMUTE_INVERSE_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (out_hs_c) begin
        if (last_c) begin
          line_cnt   <= '0;
          frame_done <= 1'b1;
        end else begin
          line_cnt <= line_cnt + CNT_W'(1);
        end
      end

      case (state)
        IDLE, HOLD: begin
          if (in_hs_c) begin
            data_q <= bus.in_line;
            left_q <= bus.passes;
            busy   <= 1'b1;
`ifdef PERMUTE_INVERSE_EN
            inv_q  <= bus.inverse;
`endif
            if (bus.passes != 3'd0) begin
              state       <= PERM;
              out_valid_q <= 1'b0;
            end else begin
              state       <= HOLD;
              out_valid_q <= 1'b1;
            end
          end else if ((state == HOLD) && out_hs_c) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
          end
        end
        PERM: begin
`ifdef PERMUTE_INVERSE_EN
          data_q <= inv_q ? pi_inv(data_q) : pi_fwd(data_q);
`else
          data_q <= pi_fwd(data_q);
`endif
          left_q <= left_q - 3'd1;
          if (left_q == 3'd1) begin
            state       <= HOLD;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
